scaler_cmd_tx: RTL and testbench

SCALER_CMD_TX -- requirements
Module: scaler_cmd_tx

---
 rtl/scaler_cmd_tx.sv | 171 +++++++++++++++++
 tb/tb_scaler_cmd_tx.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/scaler_cmd_tx.sv
// Pulse-train transmitter that steps a remote scaler to a target value in +/-10 increments.
// Optional commit phase on o_External_sync is built when CMD_TX_SYNC_EN is defined.
module scaler_cmd_tx #(
  parameter int PULSE_HI = 4,
  parameter int PULSE_LO = 4,
  parameter int VAL_MIN  = 110,
  parameter int VAL_MAX  = 400
) (
  input  logic        i_Sys_clk,
  input  logic        i_Rst,
  input  logic        i_Start,
  input  logic [11:0] i_Target,
  output logic        o_Cmd_1,
  output logic        o_Cmd_2,
  output logic        o_External_sync,
  output logic        o_Busy,
  output logic        o_Done,
  output logic [11:0] o_Value
);

  localparam logic [11:0] MIN_V   = 12'(VAL_MIN);
  localparam logic [11:0] MAX_V   = 12'(VAL_MAX);
  localparam logic [11:0] STEP    = 12'd10;
  localparam logic [7:0]  HI_LAST = 8'(PULSE_HI - 1);
  localparam logic [7:0]  LO_LAST = 8'(PULSE_LO - 1);

  typedef enum logic [2:0] {
    IDLE, CMP, UP_HI, DN_HI, GAP, SYNC_HI, SYNC_LO, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [11:0] eff_q, eff_d;
  logic [11:0] value_d;
  logic        cmd1_d, cmd2_d, busy_d, done_d;
  logic [11:0] clamped;
  logic        step_up, step_dn;

`ifdef CMD_TX_SYNC_EN
  logic sync_q, sync_d;
  assign o_External_sync = sync_q;
`else
  assign o_External_sync = 1'b0;
`endif

  assign clamped = (i_Target < MIN_V) ? MIN_V :
                   (i_Target > MAX_V) ? MAX_V : i_Target;
  // Widened so the +10 probe cannot wrap near the top of the 12-bit range.
  assign step_up = ({1'b0, o_Value} + 13'd10) <= {1'b0, eff_q};
  assign step_dn = o_Value > eff_q;

  // Every output is the registered copy of its *_d value, so each transition
  // below also decides what the lines look like in the first cycle of the new state.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    eff_d   = eff_q;
    value_d = o_Value;
    cmd1_d  = o_Cmd_1;
    cmd2_d  = o_Cmd_2;
    busy_d  = o_Busy;
    done_d  = 1'b0;
`ifdef CMD_TX_SYNC_EN
    sync_d  = sync_q;
`endif
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (i_Start) begin
          eff_d   = clamped;
          busy_d  = 1'b1;
          state_d = CMP;
        end
      end
      CMP: begin
        cnt_d = '0;
        if (step_up) begin
          state_d = UP_HI;
          cmd1_d  = 1'b1;
          value_d = o_Value + STEP;
        end else if (step_dn) begin
          state_d = DN_HI;
          cmd2_d  = 1'b1;
          value_d = o_Value - STEP;
        end else begin
`ifdef CMD_TX_SYNC_EN
          state_d = SYNC_HI;
          sync_d  = 1'b1;
`else
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
`endif
        end
      end
      UP_HI, DN_HI: begin
        if (cnt_q == HI_LAST) begin
          state_d = GAP;
          cnt_d   = '0;
          cmd1_d  = 1'b0;
          cmd2_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      GAP: begin
        if (cnt_q == LO_LAST) begin
          state_d = CMP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
`ifdef CMD_TX_SYNC_EN
      SYNC_HI: begin
        if (cnt_q == HI_LAST) begin
          state_d = SYNC_LO;
          cnt_d   = '0;
          sync_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      SYNC_LO: begin
        if (cnt_q == LO_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_Sys_clk) begin
    if (i_Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      eff_q   <= MIN_V;
      o_Value <= MIN_V;
      o_Cmd_1 <= 1'b0;
      o_Cmd_2 <= 1'b0;
      o_Busy  <= 1'b0;
      o_Done  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      eff_q   <= eff_d;
      o_Value <= value_d;
      o_Cmd_1 <= cmd1_d;
      o_Cmd_2 <= cmd2_d;
      o_Busy  <= busy_d;
      o_Done  <= done_d;
    end
  end

`ifdef CMD_TX_SYNC_EN
  always_ff @(posedge i_Sys_clk) begin
    if (i_Rst) sync_q <= 1'b0;
    else       sync_q <= sync_d;
  end
`endif

endmodule

// File: tb/tb_scaler_cmd_tx.sv
// Self-checking bench for scaler_cmd_tx: directed scenarios plus random targets
// checked against an arithmetic model of the far-end scaler.
module tb_scaler_cmd_tx;

  localparam int PULSE_HI = 4;
  localparam int PULSE_LO = 4;
  localparam int VAL_MIN  = 110;
  localparam int VAL_MAX  = 400;
  localparam int BUDGET   = 2000;
`ifdef CMD_TX_SYNC_EN
  localparam int SYNC_PULSES = 1;
`else
  localparam int SYNC_PULSES = 0;
`endif

  logic        i_Sys_clk = 1'b0;
  logic        i_Rst     = 1'b1;
  logic        i_Start   = 1'b0;
  logic [11:0] i_Target  = '0;
  logic        o_Cmd_1, o_Cmd_2, o_External_sync, o_Busy, o_Done;
  logic [11:0] o_Value;

  int errors = 0;
  int checks = 0;
  int model_val;

  scaler_cmd_tx #(
    .PULSE_HI(PULSE_HI), .PULSE_LO(PULSE_LO), .VAL_MIN(VAL_MIN), .VAL_MAX(VAL_MAX)
  ) dut (
    .i_Sys_clk      (i_Sys_clk),
    .i_Rst          (i_Rst),
    .i_Start        (i_Start),
    .i_Target       (i_Target),
    .o_Cmd_1        (o_Cmd_1),
    .o_Cmd_2        (o_Cmd_2),
    .o_External_sync(o_External_sync),
    .o_Busy         (o_Busy),
    .o_Done         (o_Done),
    .o_Value        (o_Value)
  );

  always #5 i_Sys_clk = ~i_Sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drives one start and watches the whole sequence; inject_k > 0 re-pulses i_Start mid-run.
  task automatic run_seq(input int target, input int inject_k);
    int eff, final_v, n_exp;
    int ups, dns, syncs, sync_cyc, hi_run, lo_run, bad_hi, bad_lo, bad_val, both, busy_bad;
    logic p1, p2, ps, pline, seen, got_done;
    logic [11:0] pval;
    eff     = (target < VAL_MIN) ? VAL_MIN : (target > VAL_MAX) ? VAL_MAX : target;
    final_v = VAL_MIN + ((eff - VAL_MIN) / 10) * 10;
    n_exp   = (final_v >= model_val) ? (final_v - model_val) / 10 : (model_val - final_v) / 10;
    {ups, dns, syncs, sync_cyc, hi_run, lo_run, bad_hi, bad_lo, bad_val, both, busy_bad} = '0;
    {p1, p2, ps, pline, seen, got_done} = '0;

    @(negedge i_Sys_clk);
    i_Target = 12'(target);
    i_Start  = 1'b1;
    @(negedge i_Sys_clk);
    i_Start  = 1'b0;
    i_Target = 12'($urandom_range(0, 4095));
    check($sformatf("busy_n1(t=%0d)", target), o_Busy, 1);
    check("lines_low_n1", {o_Cmd_1, o_Cmd_2, o_External_sync}, 3'b000);
    pval = o_Value;

    for (int k = 2; k < BUDGET; k++) begin
      if (k == inject_k) begin
        i_Start  = 1'b1;
        i_Target = 12'd300;
      end else begin
        i_Start = 1'b0;
      end
      @(negedge i_Sys_clk);
      if (k == 2)
        check("first_pulse_n2", o_Cmd_1 | o_Cmd_2 | o_External_sync | o_Done, 1);
      if (o_Cmd_1 && !p1) ups++;
      if (o_Cmd_2 && !p2) dns++;
      if (o_External_sync && !ps) syncs++;
      if (o_External_sync) sync_cyc++;
      if (o_Cmd_1 && o_Cmd_2) both++;
      if (o_Value !== 12'(int'(pval) + ((o_Cmd_1 && !p1) ? 10 : 0) - ((o_Cmd_2 && !p2) ? 10 : 0)))
        bad_val++;
      if (o_Cmd_1 | o_Cmd_2 | o_External_sync) begin
        if (!pline) begin
          if (seen && lo_run < PULSE_LO) bad_lo++;
          seen   = 1'b1;
          lo_run = 0;
        end
        hi_run++;
      end else begin
        if (pline) begin
          if (hi_run != PULSE_HI) bad_hi++;
          hi_run = 0;
        end
        lo_run++;
      end
      if (o_Done) begin
        got_done = 1'b1;
        check("busy_low_at_done", o_Busy, 0);
        break;
      end
      if (!o_Busy) busy_bad++;
      p1 = o_Cmd_1; p2 = o_Cmd_2; ps = o_External_sync;
      pline = o_Cmd_1 | o_Cmd_2 | o_External_sync;
      pval  = o_Value;
    end
    i_Start = 1'b0;

    check($sformatf("done_seen(t=%0d)", target), got_done, 1);
    check("up_pulses", ups, (final_v >= model_val) ? n_exp : 0);
    check("down_pulses", dns, (final_v < model_val) ? n_exp : 0);
    check("sync_pulses", syncs, SYNC_PULSES);
    check("sync_high_cycles", sync_cyc, SYNC_PULSES * PULSE_HI);
    check("pulse_hi_width_errs", bad_hi, 0);
    check("pulse_lo_width_errs", bad_lo, 0);
    check("value_step_errs", bad_val, 0);
    check("cmd_both_high", both, 0);
    check("busy_dropped_early", busy_bad, 0);
    check($sformatf("final_value(t=%0d)", target), o_Value, final_v);
    @(negedge i_Sys_clk);
    check("done_one_cycle", o_Done, 0);
    check("busy_after_done", o_Busy, 0);
    model_val = final_v;
  endtask

  // Aborts a climb toward 400 during its third up pulse.
  task automatic reset_mid;
    int rises, dones;
    logic p1;
    rises = 0; dones = 0; p1 = 1'b0;
    @(negedge i_Sys_clk);
    i_Target = 12'd400;
    i_Start  = 1'b1;
    @(negedge i_Sys_clk);
    i_Start = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge i_Sys_clk);
      if (o_Cmd_1 && !p1) rises++;
      p1 = o_Cmd_1;
      if (rises == 3) break;
    end
    check("third_up_pulse_seen", rises, 3);
    check("cmd1_high_before_rst", o_Cmd_1, 1);
    i_Rst = 1'b1;
    @(negedge i_Sys_clk);
    check("rst_mid_lines", {o_Cmd_1, o_Cmd_2, o_External_sync}, 3'b000);
    check("rst_mid_value", o_Value, VAL_MIN);
    check("rst_mid_busy_done", {o_Busy, o_Done}, 2'b00);
    i_Rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge i_Sys_clk);
      if (o_Done || o_Busy || o_Cmd_1) dones++;
    end
    check("no_activity_after_rst", dones, 0);
    model_val = VAL_MIN;
  endtask

  initial begin
    i_Rst = 1'b1;
    repeat (3) @(negedge i_Sys_clk);
    check("rst_value", o_Value, VAL_MIN);
    check("rst_outputs", {o_Cmd_1, o_Cmd_2, o_External_sync, o_Busy, o_Done}, 5'b0);
    i_Rst = 1'b0;
    model_val = VAL_MIN;

    run_seq(150, 0);
    run_seq(135, 0);
    run_seq(130, 0);
    run_seq(50, 0);
    run_seq(4000, 0);
    run_seq(200, 7);
    reset_mid();
    run_seq(200, 0);
    for (int r = 0; r < 8; r++)
      run_seq(int'($urandom_range(0, 600)), (r % 2 == 1) ? int'($urandom_range(3, 12)) : 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
